cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling responder that sits between an L1 cache (instruction or data) and the multi-cycle main memory. When the cache flags a miss, the block holds the requester stalled via `fsm_busy` and fetches the 16-byte block containing the miss address as 8 word reads. It writes each returned word into the cache data array and writes the tag on the final word. One instance serves the I-side and one the D-side; their `fsm_busy` outputs feed the hazard unit as `i_fsm_busy` / `d_fsm_busy`.

## Interface
- `WORDS`, 8, words per cache block (power of two; block = 2*WORDS bytes)
- `ADDR_W`, 16, byte-address width
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `miss_detected` in 1: cache miss this cycle; requester holds it high until `fsm_busy` falls
- `miss_address` in `ADDR_W`: byte address of the missing access; valid with `miss_detected`
- `fsm_busy` out 1: fill in progress; requester must stall
- `memory_read` out 1: read request to main memory this cycle
- `memory_address` out `ADDR_W`: word-aligned read address
- `memory_data_valid` in 1: main memory returns one word this cycle, in request order
- `memory_data` in 16: returned word
- `write_data_array` out 1: write `fill_data` into the data array at `word_index`
- `word_index` out log2(`WORDS`): word offset within the block
- `fill_data` out 16: equals `memory_data`, combinational pass-through
- `write_tag_array` out 1: write tag/valid for `block_address`
- `block_address` out `ADDR_W`: latched miss address with the low log2(2*WORDS) bits cleared

## Operation
- There are two states: IDLE and FILL.
- IDLE:
  - `fsm_busy` = `miss_detected`, combinational, so the stall takes effect in the miss cycle.
  - On `miss_detected`: latch `block_address` = `miss_address` & ~(2*WORDS-1), clear `issue_cnt` and `recv_cnt`, then go to FILL.
- FILL:
  - `fsm_busy` = 1.
  - Issue side: while `issue_cnt` < `WORDS`, drive `memory_read`=1 and `memory_address` = `block_address` + 2*`issue_cnt`, and increment `issue_cnt` each cycle. After all `WORDS` reads are issued, `memory_read`=0.
  - Receive side: on `memory_data_valid`, assert `write_data_array`=1 with `word_index`=`recv_cnt` and increment `recv_cnt`.
  - When `memory_data_valid` arrives with `recv_cnt`=`WORDS`-1: assert `write_tag_array`=1 in the same cycle and return to IDLE at the next edge.
- Issue and receive overlap. Address arithmetic is modulo 2^`ADDR_W`; counters are log2(`WORDS`)+1 bits wide.
- Outputs when not active:
  - `memory_address` = `block_address` whenever `memory_read`=0.
  - `word_index` = `recv_cnt` low bits; its value is don't-care when `write_data_array`=0.
- Boundary rules:
  - `memory_data_valid` in IDLE is ignored: no writes occur and no state changes.
  - `miss_detected` or a changed `miss_address` during FILL is ignored; the latched block is used.
  - A miss in the first IDLE cycle after a fill starts a new fill; there are no bubble requirements.
  - `memory_data_valid` in FILL before any read has been issued cannot occur; behaviour is unspecified.
  - `rst` mid-fill: return to IDLE and clear all counters and `block_address`. Outstanding memory returns are ignored. Main memory shares `rst`, so no stale data follows.
- Reset values: state IDLE, `block_address`=0, counters=0. Every registered and control output is 0: `fsm_busy` (given `miss_detected`=0), `memory_read`, `memory_address`, `write_data_array`, `write_tag_array`, `word_index`.

## Timing
- The miss is seen at cycle 0 in IDLE, where `fsm_busy`=1 combinationally.
- Reads are issued in cycles 1..`WORDS`, one per cycle, with addresses ascending from `block_address`.
- For memory latency L (valid in cycle c+L for a read issued in cycle c), data writes occur in cycles 1+L..`WORDS`+L.
- `write_tag_array` coincides with the last data write.
- `fsm_busy` is 1 in cycles 0..`WORDS`+L and falls in cycle `WORDS`+L+1.
- Default case (`WORDS`=8, L=4): busy for 13 cycles; tag write in cycle 12.
- If memory stalls (gaps in `memory_data_valid`), the fill extends by the gap count, and `fsm_busy` holds until the last word arrives.

## Test plan
- Basic fill:
  - Stimulus: `miss_address`=0x1236, L=4.
  - Required response: reads at 0x1230, 0x1232, …, 0x123E in cycles 1..8. `write_data_array` in cycles 5..12 with `word_index` 0..7 and data matching the memory model. `write_tag_array` only in cycle 12 with `block_address`=0x1230. `fsm_busy` 1 in cycles 0..12 and 0 in cycle 13.
- Wrap-around:
  - Stimulus: `miss_address`=0xFFFF.
  - Required response: `block_address`=0xFFF0, last read at 0xFFFE, no address overflow into 0x0000.
- Ignored inputs:
  - Stimulus: change `miss_address` to 0x4000 and pulse `memory_data_valid` while IDLE with no miss pending.
  - Required response: no array writes; the fill still targets the originally latched block.
- Gapped returns:
  - Stimulus: memory model withholds valid for 3 cycles after word 4.
  - Required response: writes pause; tag write and busy-fall shift by 3 cycles; `word_index` sequence is unbroken.
- Reset mid-fill:
  - Stimulus: assert `rst` in cycle 6 of a fill.
  - Required response: all outputs 0 the next cycle. A subsequent miss to 0x0040 performs a clean 8-word fill starting at `word_index` 0.
- Back-to-back misses:
  - Stimulus: second miss to 0x2000 asserted in the first IDLE cycle after a fill.
  - Required response: `fsm_busy` stays effectively continuous; the second fill's first read is issued the following cycle.

Source files
------------

// File: rtl/cache_fill_if.sv
// Miss/fill handshake between the cache, the fill responder and main memory.
// The slave modport is the fill responder's view of the bundle.
interface cache_fill_if #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
);
  localparam int IDX_W  = $clog2(WORDS);
  localparam int DATA_W = 16;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;
  logic              memory_read;
  logic [ADDR_W-1:0] memory_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;
  logic [ADDR_W-1:0] block_address;

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_read, memory_address, write_data_array,
           word_index, fill_data, write_tag_array, block_address
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_read, memory_address, write_data_array,
           word_index, fill_data, write_tag_array, block_address
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches one block as WORDS pipelined word reads and
// writes each returned word into the data array, the tag on the last word.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  cache_fill_if.slave   bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(2 * WORDS);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] block_addr;
  logic              issue;
  logic              recv;
  logic              last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      block_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (bus.miss_detected) begin
          block_addr <= {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          issue_cnt  <= '0;
          recv_cnt   <= '0;
        end
      end else begin
        if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
        if (recv)  recv_cnt  <= recv_cnt + CNT_W'(1);
      end
    end
  end

  // Busy is combinational in IDLE so the requester stalls in the miss cycle itself.
  always_comb begin
    state_nxt            = state;
    bus.fsm_busy         = 1'b0;
    bus.memory_read      = 1'b0;
    bus.memory_address   = block_addr;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    issue                = 1'b0;
    recv                 = 1'b0;
    last                 = 1'b0;
    case (state)
      IDLE: begin
        bus.fsm_busy = bus.miss_detected;
        if (bus.miss_detected) state_nxt = FILL;
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        issue        = (issue_cnt < CNT_W'(WORDS));
        recv         = bus.memory_data_valid;
        last         = recv && (recv_cnt == CNT_W'(WORDS - 1));
        bus.memory_read = issue;
        if (issue) bus.memory_address = block_addr + ADDR_W'({issue_cnt, 1'b0});
        bus.write_data_array = recv;
        bus.write_tag_array  = last;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.word_index    = recv_cnt[IDX_W-1:0];
  assign bus.fill_data     = bus.memory_data;
  assign bus.block_address = block_addr;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a latency/gap memory model and a
// transaction-level scoreboard of expected reads and writes per fill.
module tb_cache_fill_fsm;
  localparam int WORDS  = 8;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_if #(.WORDS(WORDS), .ADDR_W(ADDR_W)) bus ();
  cache_fill_fsm #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int due; logic [15:0] addr;} ret_t;

  logic [15:0] mem [0:32767];
  ret_t        ret_q[$];
  logic [15:0] rd_q[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  bit          act;
  logic [15:0] ref_blk;
  int          nrecv, ndeliv, hold, gap_after, gap_len, lat;
  bit          noise;
  int          miss_cyc, first_rd, tag_cyc;
  logic [15:0] last_rd_addr;
  logic        req_miss, req_rst;
  logic [15:0] req_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: drive inputs after the edge, compare at the falling edge.
  task automatic cycle();
    bit          act0, exp_rd, exp_wr;
    logic [15:0] wa;
    @(posedge clk);
    #1;
    cyc++;
    rst                   = req_rst;
    bus.miss_detected     = req_miss;
    bus.miss_address      = req_addr;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'($urandom);
    if (hold > 0) hold--;
    else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = mem[ret_q[0].addr[15:1]];
      void'(ret_q.pop_front());
      ndeliv++;
      if (ndeliv == gap_after) hold = gap_len;
    end else if (noise && !act && ret_q.size() == 0 && $urandom_range(0, 2) == 0)
      bus.memory_data_valid = 1'b1;
    @(negedge clk);
    if (req_rst) begin
      act = 0; ref_blk = '0; rd_q.delete(); ret_q.delete(); hold = 0;
      return;
    end
    act0 = act;
    check("busy", bus.fsm_busy, act0 || req_miss);
    exp_rd = act0 && rd_q.size() > 0;
    check("mem_read", bus.memory_read, exp_rd);
    if (exp_rd) begin
      check("rd_addr", bus.memory_address, rd_q[0]);
      if (first_rd < 0) first_rd = cyc;
      last_rd_addr = rd_q[0];
      void'(rd_q.pop_front());
    end else begin
      check("idle_addr", bus.memory_address, ref_blk);
    end
    if (bus.memory_read) ret_q.push_back('{cyc + lat, bus.memory_address});
    exp_wr = act0 && bus.memory_data_valid;
    check("data_wr", bus.write_data_array, exp_wr);
    check("tag_wr", bus.write_tag_array, exp_wr && nrecv == WORDS - 1);
    check("blk", bus.block_address, ref_blk);
    if (exp_wr) begin
      wa = ref_blk + 16'(2 * nrecv);
      check("widx", bus.word_index, nrecv);
      check("wdata", bus.fill_data, mem[wa[15:1]]);
      nrecv++;
      if (nrecv == WORDS) begin act = 0; tag_cyc = cyc; end
    end
    if (!act0 && req_miss) begin
      ref_blk = req_addr & 16'hFFF0;
      rd_q.delete();
      for (int i = 0; i < WORDS; i++) rd_q.push_back(ref_blk + 16'(2 * i));
      nrecv = 0; ndeliv = 0; act = 1; miss_cyc = cyc; first_rd = -1;
    end
  endtask

  task automatic idle(input int n, input bit noisy);
    req_miss = 1'b0;
    noise    = noisy;
    repeat (n) cycle();
    noise    = 1'b0;
  endtask

  // Complete fill; rst_at > 0 asserts rst in that cycle of the fill.
  task automatic run_fill(input logic [15:0] addr, input int l, input int ga,
                          input int gl, input int rst_at);
    int n;
    bit reset_hit;
    lat = l; gap_after = ga; gap_len = gl; tag_cyc = -1; reset_hit = 0;
    req_miss = 1'b1; req_addr = addr;
    cycle();
    n = 0;
    while (act && n < 100) begin
      n++;
      if (n == 2) req_addr = 16'h4000 ^ 16'($urandom_range(0, 255));
      if (rst_at > 0 && n == rst_at) begin req_rst = 1'b1; reset_hit = 1; end
      cycle();
      req_rst = 1'b0;
      if (reset_hit) break;
    end
    if (n >= 100) check("fill_timeout", 32'd1, 32'd0);
    if (!reset_hit) begin
      check("first_rd_lat", first_rd - miss_cyc, 1);
      check("tag_lat", tag_cyc - miss_cyc,
            WORDS + l + ((ga > 0 && ga < WORDS) ? gl : 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst = 1'b1; req_rst = 1'b1; req_miss = 1'b0; req_addr = '0;
    bus.miss_detected = 1'b0; bus.miss_address = '0;
    bus.memory_data_valid = 1'b0; bus.memory_data = '0;
    act = 0; ref_blk = '0; hold = 0; lat = 4; noise = 0;
    gap_after = 0; gap_len = 0; first_rd = -1;
    cycle(); cycle();
    req_rst = 1'b0;
    idle(2, 0);
    check("rst_widx", bus.word_index, 0);
    check("rst_blk", bus.block_address, 16'h0000);

    run_fill(16'h1236, 4, 0, 0, 0);
    check("basic_tag_cycle", tag_cyc - miss_cyc, 12);
    check("basic_blk", bus.block_address, 16'h1230);
    check("basic_last_rd", last_rd_addr, 16'h123E);
    idle(1, 0);
    check("basic_busy_fall", bus.fsm_busy, 1'b0);

    run_fill(16'hFFFF, 4, 0, 0, 0);
    check("wrap_blk", bus.block_address, 16'hFFF0);
    check("wrap_last_rd", last_rd_addr, 16'hFFFE);
    idle(1, 0);

    req_addr = 16'h4000;
    idle(8, 1);
    run_fill(16'h0A10, 3, 0, 0, 0);
    check("ign_blk", bus.block_address, 16'h0A10);
    idle(2, 1);

    run_fill(16'h3456, 4, 4, 3, 0);
    check("gap_tag_cycle", tag_cyc - miss_cyc, 15);
    idle(1, 0);
    check("gap_busy_fall", bus.fsm_busy, 1'b0);

    run_fill(16'h5550, 4, 0, 0, 6);
    idle(1, 0);
    check("midrst_blk", bus.block_address, 16'h0000);
    check("midrst_read", bus.memory_read, 1'b0);
    run_fill(16'h0040, 4, 0, 0, 0);
    check("post_rst_blk", bus.block_address, 16'h0040);

    run_fill(16'h1000, 2, 0, 0, 0);
    run_fill(16'h2000, 4, 0, 0, 0);
    check("b2b_blk", bus.block_address, 16'h2000);
    idle(1, 0);

    for (int k = 0; k < 12; k++) begin
      run_fill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 7),
               $urandom_range(1, 4), 0);
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 3), 1);
    end
    idle(2, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
